reg8_sel_encoder: RTL and testbench
===================================

// Module: reg8_sel_encoder
// PURPOSE
// Sequential encoder: the inverse of the register-file write-enable decoder.
// - Accepts an 8-bit multi-hot enable vector, one register per bit.
// - Emits the 4-bit wsel index of each set bit, lowest index first.
// - Uses a valid/ready handshake and emits one index per accepted transfer.
// - Sits between bulk-write/scan logic and the reg8file write port, so any
//   enable mask can be replayed as a sequence of single-register wsel writes.
// PARAMETERS
// N      8  number of enable lines; N <= 2**SEL_W
// SEL_W  4  width of out_sel; matches the wsel width of the reg8file port
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      synchronous reset, active high
// in_en      in   N      multi-hot enable mask, bit i = register i
// in_valid   in   1      in_en is valid this cycle
// in_ready   out  1      block can accept a mask (high only in IDLE)
// out_sel    out  SEL_W  index of the lowest pending set bit
// out_valid  out  1      out_sel is valid
// out_ready  in   1      consumer accepts out_sel this cycle
// out_last   out  1      out_sel is the final index of the current mask
// empty_err  out  1      one-cycle pulse: an all-zero mask was accepted
// busy       out  1      high while in EMIT
// BEHAVIOUR
// - Reset values (rst high at a clk edge):
//   - State IDLE, pending = 0.
//   - out_valid, out_last, empty_err, busy = 0; out_sel = 0; in_ready = 1.
//   - rst overrides every other input in the same cycle.
// - States: IDLE and EMIT.
// - IDLE:
//   - in_ready = 1, out_valid = 0.
//   - If in_valid is high at an edge, pending <= in_en.
//   - If in_en != 0, the next state is EMIT.
//   - If in_en == 0, the next state stays IDLE and empty_err = 1 for exactly the next cycle.
// - EMIT:
//   - in_ready = 0, busy = 1, out_valid = 1.
//   - out_sel is the zero-extended index of the lowest set bit of pending.
//   - out_last = 1 when pending has exactly one set bit.
//   - On out_valid & out_ready, that bit of pending is cleared.
//   - If out_last was high during that transfer, the next state is IDLE.
//   - Otherwise the block stays in EMIT.
// - Latency and throughput:
//   - Mask accepted at edge T gives the first out_valid in cycle T+1.
//   - With out_ready held high, a mask with k set bits emits on k consecutive cycles.
//   - in_ready returns high in the cycle after the last transfer.
// - Backpressure: while out_valid=1 and out_ready=0, out_sel, out_last and pending hold stable.
// - out_sel, out_last, busy and out_valid are decoded from the state and pending registers only.
//   No input feeds them combinationally.
// - in_valid during EMIT is ignored; the mask is not captured and the source must hold it.
// - Upper bits of out_sel above clog2(N) are always 0.
// - Reset in mid-EMIT: the remaining pending bits are discarded and no further out_valid follows.
// - X/Z on in_en while in_valid=0 has no effect.
// TESTING
// 1. Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, out_sel=0, busy=0, empty_err=0.
// 2. in_en=8'b00000100, in_valid 1 cycle, out_ready=1
//    -> cycle T+1: out_sel=2, out_last=1; cycle T+2: IDLE, in_ready=1.
// 3. in_en=8'b10100101, out_ready=1
//    -> out_sel = 0,2,5,7 on T+1..T+4; out_last only with 7; in_ready=1 at T+5.
// 4. in_en=8'b00010010, out_ready low for 3 cycles, then high
//    -> out_sel=1 held 3 cycles, then 1, then 4 (last).
// 5. in_en=8'h00 accepted -> empty_err=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
// 6. in_en=8'hFF, rst after 3 transfers (0,1,2)
//    -> next cycle out_valid=0, in_ready=1; a new mask 8'h80 then yields out_sel=7, out_last=1.

Source files
------------

// File: rtl/reg8_sel_encoder.sv
// Sequential encoder: accepts a multi-hot enable mask and replays it as a
// stream of single-register write-select indices, lowest index first.
module reg8_sel_encoder #(
    parameter int N     = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             empty_err,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    pending_reg, pending_next;
    logic            empty_err_reg, empty_err_next;

    logic [N-1:0]    below_any;
    logic [N-1:0]    lowest_onehot;
    logic [SEL_W-1:0] sel_idx;
    logic            single_bit;

    // below_any[i] is set when some pending bit sits strictly below bit i
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_prefix
            if (gi == 0) begin : g_first
                assign below_any[gi] = 1'b0;
            end else begin : g_rest
                assign below_any[gi] = below_any[gi-1] | pending_reg[gi-1];
            end
        end
    endgenerate

    assign lowest_onehot = pending_reg & ~below_any;
    assign single_bit    = (pending_reg != '0) && (pending_reg == lowest_onehot);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (lowest_onehot[i]) begin
                sel_idx = sel_idx | SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            empty_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            empty_err_reg <= empty_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        empty_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    pending_next = in_en;
                    if (in_en != '0) begin
                        state_next = EMIT;
                    end else begin
                        empty_err_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                // in_valid is deliberately ignored here; the source holds its mask
                if (out_ready) begin
                    pending_next = pending_reg & ~lowest_onehot;
                    if (single_bit) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    // Outputs come from registered state only, never combinationally from inputs
    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == EMIT);
    assign out_valid = (state_reg == EMIT);
    assign out_sel   = (state_reg == EMIT) ? sel_idx : '0;
    assign out_last  = (state_reg == EMIT) && single_bit;
    assign empty_err = empty_err_reg;

endmodule

// File: tb/tb_reg8_sel_encoder.sv
// Directed bench for reg8_sel_encoder: a queue-of-indices model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_reg8_sel_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_en;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_sel;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       empty_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg8_sel_encoder #(.N(8), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .empty_err (empty_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model: the indices still to be emitted, in order
    int unsigned exp_q[$];
    logic        exp_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (exp_q.size() == 0) begin
                if (in_valid) begin
                    if (in_en == 8'h00) begin
                        exp_err = 1'b1;
                    end else begin
                        for (int b = 0; b < 8; b++) begin
                            if (in_en[b]) exp_q.push_back(b);
                        end
                    end
                end
            end else if (out_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_compare();
        int ev, es, el;
        ev = (exp_q.size() != 0) ? 1 : 0;
        es = ev ? int'(exp_q[0]) : 0;
        el = (exp_q.size() == 1) ? 1 : 0;
        chk("model out_valid", int'(out_valid), ev);
        chk("model busy",      int'(busy),      ev);
        chk("model in_ready",  int'(in_ready),  1 - ev);
        chk("model out_sel",   int'(out_sel),   es);
        chk("model out_last",  int'(out_last),  el);
        chk("model empty_err", int'(empty_err), int'(exp_err));
    endtask

    // One clock: inputs already set are sampled at the rising edge; compare on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_compare();
        $display("cyc t=%0t rst=%0b in_v=%0b in_en=%02h in_rdy=%0b out_v=%0b out_rdy=%0b sel=%0d last=%0b err=%0b",
                 $time, rst, in_valid, in_en, in_ready, out_valid, out_ready, out_sel, out_last, empty_err);
    endtask

    task automatic accept(input logic [7:0] m);
        in_en    = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_en    = 8'h00;
    endtask

    initial begin
        int a5_sel[4];
        logic [7:0] masks[6];
        a5_sel = '{0, 2, 5, 7};
        masks  = '{8'h81, 8'h3C, 8'h01, 8'h00, 8'h6A, 8'hFF};

        rst = 1'b1; in_en = 8'h00; in_valid = 1'b0; out_ready = 1'b1;

        // Reset held two cycles
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready",  int'(in_ready),  1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_sel",   int'(out_sel),   0);
        chk("reset busy",      int'(busy),      0);
        chk("reset empty_err", int'(empty_err), 0);

        // Single bit mask
        accept(8'b0000_0100);
        chk("t2 out_valid", int'(out_valid), 1);
        chk("t2 out_sel",   int'(out_sel),   2);
        chk("t2 out_last",  int'(out_last),  1);
        chk("t2 in_ready",  int'(in_ready),  0);
        tick();
        chk("t2 idle in_ready", int'(in_ready),  1);
        chk("t2 idle out_valid", int'(out_valid), 0);

        // Four bit mask, with a competing mask offered mid-stream that must be ignored
        accept(8'b1010_0101);
        for (int k = 0; k < 4; k++) begin
            chk("t3 out_sel",  int'(out_sel),  a5_sel[k]);
            chk("t3 out_last", int'(out_last), (k == 3) ? 1 : 0);
            in_valid = (k == 1);
            in_en    = (k == 1) ? 8'h02 : 8'h00;
            tick();
        end
        in_valid = 1'b0;
        chk("t3 in_ready T+5", int'(in_ready), 1);
        chk("t3 out_valid T+5", int'(out_valid), 0);

        // Backpressure holds out_sel
        out_ready = 1'b0;
        accept(8'b0001_0010);
        for (int k = 0; k < 3; k++) begin
            chk("t4 held out_sel",  int'(out_sel),  1);
            chk("t4 held out_last", int'(out_last), 0);
            tick();
        end
        out_ready = 1'b1;
        chk("t4 out_sel first", int'(out_sel), 1);
        tick();
        chk("t4 out_sel second", int'(out_sel), 4);
        chk("t4 out_last second", int'(out_last), 1);
        tick();
        chk("t4 idle", int'(in_ready), 1);

        // Empty mask
        accept(8'h00);
        chk("t5 empty_err", int'(empty_err), 1);
        chk("t5 out_valid", int'(out_valid), 0);
        chk("t5 in_ready",  int'(in_ready),  1);
        tick();
        chk("t5 empty_err clears", int'(empty_err), 0);

        // Reset mid-emit
        accept(8'hFF);
        chk("t6 sel0", int'(out_sel), 0);
        tick();
        chk("t6 sel1", int'(out_sel), 1);
        tick();
        chk("t6 sel2", int'(out_sel), 2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 post-reset out_valid", int'(out_valid), 0);
        chk("t6 post-reset in_ready",  int'(in_ready),  1);
        accept(8'h80);
        chk("t6 new sel",  int'(out_sel),  7);
        chk("t6 new last", int'(out_last), 1);
        tick();

        // Mixed masks with irregular backpressure, checked by the model alone
        for (int m = 0; m < 6; m++) begin
            accept(masks[m]);
            for (int c = 0; c < 20; c++) begin
                out_ready = ((c % 3) != 1);
                tick();
            end
            out_ready = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
